// File: rtl/pipe_seq_pkg.sv
// Shared types and helpers for the pipe sequencer: the job FSM state
// encoding and the sizing rule for the downstream credit counter.
package pipe_seq_pkg;

    // Job lifecycle: wait for a job, issue its beats, wait for the tail to
    // leave the datapath, then pulse completion for one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // The credit counter must hold every value from 0 up to and including
    // the full buffer depth, hence credits + 1 distinct values.
    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/valid_tag_pipe.sv
// One-bit delay line that shadows the datapath delay stages. A beat enters
// as a 1 on the issuing cycle and leaves exactly DEPTH clock edges later,
// so its latency equals the datapath latency by construction.
module valid_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tag_in,
    output logic tag_out
);

    logic [DEPTH-1:0] tag_r;

    // Advance the tag line every cycle; reset or clear drops all in-flight tags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_r <= '0;
        end else if (clr) begin
            tag_r <= '0;
        end else begin
            tag_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // The last stage is the tag that lines up with the datapath output
    assign tag_out = tag_r[DEPTH-1];

endmodule

// File: rtl/pipe_sequencer.sv
// Sequences one job of N beats through a fixed-latency datapath that cannot
// stall. Beats are issued in index order while downstream credits remain,
// a tag line follows each beat through the datapath, and the job completes
// once the last beat has appeared at the datapath output.
module pipe_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int DP_LATENCY = 2,
    parameter int CNT_W      = 16,
    parameter int CREDITS    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] beat_count,
    output logic             busy,
    output logic             done,
    output logic             issue_valid,
    output logic [CNT_W-1:0] issue_index,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_index,
    input  logic             out_ack,
    output logic             credit_err
);

    localparam int               CRED_W   = credit_width(CREDITS);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    seq_state_t        state_r;
    logic [CNT_W-1:0]  n_r;
    logic [CNT_W-1:0]  issued_r;
    logic [CNT_W-1:0]  retired_r;
    logic [CRED_W-1:0] credits_r;
    logic              credit_err_r;
    logic              busy_r;
    logic              done_r;

    logic              issue_fire_s;
    logic              tag_out_s;
    logic              last_issue_s;
    logic              last_retire_s;

    // A beat goes out whenever the job is issuing and the downstream buffer
    // has room; the datapath itself has no back-pressure.
    assign issue_fire_s  = (state_r == ISSUE) && (credits_r != {CRED_W{1'b0}});
    assign last_issue_s  = issue_fire_s && (issued_r == (n_r - CNT_ONE));
    assign last_retire_s = tag_out_s && ((retired_r + CNT_ONE) == n_r);

    // Tag line mirroring the datapath delay stages
    valid_tag_pipe #(
        .DEPTH (DP_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .tag_in  (issue_fire_s),
        .tag_out (tag_out_s)
    );

    // Job FSM: accept a job, count issued and retired beats, report completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            n_r       <= CNT_ZERO;
            issued_r  <= CNT_ZERO;
            retired_r <= CNT_ZERO;
        end else begin
            // Counters move with the beats themselves; the job accept branch
            // below overrides them when a new job starts.
            if (issue_fire_s) begin
                issued_r <= issued_r + CNT_ONE;
            end else begin
                issued_r <= issued_r;
            end
            if (tag_out_s) begin
                retired_r <= retired_r + CNT_ONE;
            end else begin
                retired_r <= retired_r;
            end

            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (start) begin
                        if (beat_count != CNT_ZERO) begin
                            n_r       <= beat_count;
                            issued_r  <= CNT_ZERO;
                            retired_r <= CNT_ZERO;
                            state_r   <= ISSUE;
                            busy_r    <= 1'b1;
                        end else begin
                            // Empty job: complete immediately, nothing issued
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    if (last_issue_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                DRAIN: begin
                    done_r <= 1'b0;
                    // The final result is on the output this cycle, so the
                    // job is finished once this edge has counted it.
                    if (last_retire_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                        busy_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Credit ledger: an issue takes a slot, out_ack returns one; a return
    // with the ledger already full is a protocol error and is latched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_r    <= CRED_MAX;
            credit_err_r <= 1'b0;
        end else begin
            case ({issue_fire_s, out_ack})
                2'b10: begin
                    credits_r <= credits_r - CRED_ONE;
                end
                2'b01: begin
                    if (credits_r < CRED_MAX) begin
                        credits_r <= credits_r + CRED_ONE;
                    end else begin
                        credits_r    <= credits_r;
                        credit_err_r <= 1'b1;
                    end
                end
                default: begin
                    // Idle, or an issue and a return cancelling each other
                    credits_r <= credits_r;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign issue_valid  = issue_fire_s;
    assign issue_index  = issued_r;
    assign result_valid = tag_out_s;
    assign result_index = retired_r;
    assign credit_err   = credit_err_r;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer (DP_LATENCY=2, CREDITS=2).
// Expected beat indices are queued when a job is launched and consumed as
// the DUT issues and retires beats; result latency is checked against the
// issue cycle. Job timing is table-driven, credit corner cases are scripted.
module tb_pipe_sequencer;

    localparam int DP_LATENCY = 2;
    localparam int CNT_W      = 16;
    localparam int CREDITS    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] beat_count;
    logic             busy;
    logic             done;
    logic             issue_valid;
    logic [CNT_W-1:0] issue_index;
    logic             result_valid;
    logic [CNT_W-1:0] result_index;
    logic             out_ack;
    logic             credit_err;

    pipe_sequencer #(
        .DP_LATENCY (DP_LATENCY),
        .CNT_W      (CNT_W),
        .CREDITS    (CREDITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .beat_count   (beat_count),
        .busy         (busy),
        .done         (done),
        .issue_valid  (issue_valid),
        .issue_index  (issue_index),
        .result_valid (result_valid),
        .result_index (result_index),
        .out_ack      (out_ack),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int iss_cnt  = 0;
    int res_cnt  = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int done_cyc = 0;
    bit mon_en   = 1'b0;

    int exp_iss_q[$];
    int exp_res_q[$];
    int lat_q[$];

    // Job table: beat count, cycles from start to done, busy cycles
    typedef struct {
        int n;
        int done_dly;
        int busy_cyc;
    } job_vec_t;
    job_vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Cycle counter: cycle k is the interval after the k-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample outputs mid-cycle and score them against the queues
    always @(negedge clk) begin
        if (mon_en) begin
            if (issue_valid === 1'b1) begin
                iss_cnt++;
                if (exp_iss_q.size() == 0) check("issue_unexpected", 1, 0);
                else check("issue_index", int'(issue_index), exp_iss_q.pop_front());
                lat_q.push_back(cyc + DP_LATENCY);
            end
            if (result_valid === 1'b1) begin
                res_cnt++;
                if (exp_res_q.size() == 0) check("result_unexpected", 1, 0);
                else check("result_index", int'(result_index), exp_res_q.pop_front());
                if (lat_q.size() != 0) check("result_latency", cyc, lat_q.pop_front());
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy === 1'b1) busy_cnt++;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        out_ack = 1'b1;
        tick(1);
        out_ack = 1'b0;
        tick(2);
    endtask

    task automatic launch(input int n, output int s);
        s = cyc;
        for (int i = 0; i < n; i++) begin
            exp_iss_q.push_back(i);
            exp_res_q.push_back(i);
        end
        start      = 1'b1;
        beat_count = CNT_W'(n);
        tick(1);
        start      = 1'b0;
        beat_count = '0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            tick(1);
            k++;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
    endtask

    task automatic run_job(input int n, input int done_dly, input int busy_cyc);
        int s, d0, b0, i0;
        d0 = done_cnt;
        b0 = busy_cnt;
        i0 = iss_cnt;
        launch(n, s);
        wait_done(d0);
        check("done_latency", done_cyc - s, done_dly);
        check("busy_cycles", busy_cnt - b0, busy_cyc);
        check("beats_issued", iss_cnt - i0, n);
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        check("results_pending", exp_res_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_issue_valid"}, int'(issue_valid), 0);
        check({tag, "_result_valid"}, int'(result_valid), 0);
        check({tag, "_credit_err"}, int'(credit_err), 0);
        check({tag, "_issue_index"}, int'(issue_index), 0);
        check({tag, "_result_index"}, int'(result_index), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d0, i0, r0;

        vecs[0] = '{n: 3, done_dly: 6, busy_cyc: 5};
        vecs[1] = '{n: 1, done_dly: 4, busy_cyc: 3};
        vecs[2] = '{n: 0, done_dly: 1, busy_cyc: 0};
        vecs[3] = '{n: 5, done_dly: 8, busy_cyc: 7};

        rst_n      = 1'b0;
        start      = 1'b0;
        beat_count = '0;
        out_ack    = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(1);

        // Credit stall: two credits, five beats, no acks
        d0 = done_cnt;
        i0 = iss_cnt;
        launch(5, s);
        tick(6);
        check("stall_issued", iss_cnt - i0, 2);
        check("stall_issue_valid", int'(issue_valid), 0);
        check("stall_busy", int'(busy), 1);
        pulse_ack();
        check("stall_after_ack1", iss_cnt - i0, 3);
        pulse_ack();
        check("stall_after_ack2", iss_cnt - i0, 4);
        tick(6);
        check("stall_not_done", done_cnt - d0, 0);
        pulse_ack();
        wait_done(d0);
        check("stall_issued_all", iss_cnt - i0, 5);
        check("stall_results", exp_res_q.size(), 0);

        // One credit, issue and ack together every issuing cycle
        pulse_ack();
        d0 = done_cnt;
        i0 = iss_cnt;
        launch(4, s);
        out_ack = 1'b1;
        tick(4);
        out_ack = 1'b0;
        wait_done(d0);
        check("oneshot_done_latency", done_cyc - s, 7);
        check("oneshot_issued", iss_cnt - i0, 4);
        // Exactly one credit must remain: a two-beat job issues once, then stalls
        d0 = done_cnt;
        i0 = iss_cnt;
        launch(2, s);
        tick(5);
        check("oneshot_credit_left", iss_cnt - i0, 1);
        pulse_ack();
        wait_done(d0);
        check("oneshot_second_job", iss_cnt - i0, 2);

        // Credit overflow flag
        check("err_clear", int'(credit_err), 0);
        pulse_ack();
        pulse_ack();
        check("err_at_full", int'(credit_err), 0);
        pulse_ack();
        check("err_set", int'(credit_err), 1);

        // Table-driven jobs with out_ack held high
        out_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_job(vecs[i].n, vecs[i].done_dly, vecs[i].busy_cyc);
        end
        check("err_sticky", int'(credit_err), 1);

        // Reset during DRAIN with beats 2 and 3 still in flight
        launch(4, s);
        tick(2);
        out_ack = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_iss_q.delete();
        exp_res_q.delete();
        lat_q.delete();
        check_idle_outputs("midreset");
        r0 = res_cnt;
        tick(6);
        check("midreset_no_results", res_cnt - r0, 0);
        run_job(1, 4, 3);
        // Credits were refilled by reset: one left after the single-beat job
        d0 = done_cnt;
        i0 = iss_cnt;
        launch(2, s);
        tick(5);
        check("midreset_credits", iss_cnt - i0, 1);
        pulse_ack();
        wait_done(d0);
        check("midreset_final_job", iss_cnt - i0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
